life_gen_sequencer: RTL and testbench

Owns the single-port 8x8 cell memory and schedules it between three users: display row scan, host seed loading, and next-generation update. During an update it feeds decoder_top with the previous, current and next rows of the old generation and writes each result back in place. It sits between the row memory, decoder_top and the LED display driver.

---
 rtl/life_gen_sequencer_if.sv | 40 ++++
 rtl/life_gen_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_life_gen_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_gen_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_sequencer_if
// Purpose  : Host load, row memory, decoder and display signals of the
//            life generation sequencer.
// Revision : 1.0
// ============================================================================
interface life_gen_sequencer_if;
  logic       load_valid;
  logic [2:0] load_row;
  logic [7:0] load_data;
  logic       load_ready;

  logic [2:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] dec_in;
  logic [7:0] dec_a;
  logic [7:0] dec_b;
  logic [7:0] dec_out;

  logic [2:0] disp_addr;
  logic [7:0] disp_row;
  logic       disp_valid;

  modport master (
    input  load_valid, load_row, load_data, mem_rdata, dec_out,
    output load_ready, mem_addr, mem_we, mem_wdata,
           dec_in, dec_a, dec_b, disp_addr, disp_row, disp_valid
  );

  modport slave (
    output load_valid, load_row, load_data, mem_rdata, dec_out,
    input  load_ready, mem_addr, mem_we, mem_wdata,
           dec_in, dec_a, dec_b, disp_addr, disp_row, disp_valid
  );
endinterface
`default_nettype wire

// File: rtl/life_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_sequencer
// Purpose  : Arbitrates the 8x8 cell memory between display scan, host loads
//            and in-place next-generation updates. Optional LIFE_STABLE_DETECT_EN
//            adds a stable output that suppresses automatic generations.
// Revision : 1.0
// ============================================================================
module life_gen_sequencer #(
  parameter int FRAMES_PER_GEN = 64,
  parameter int GEN_W          = 16
) (
  input  logic                 ph1,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 step,
  life_gen_sequencer_if.master bus,
  output logic                 busy,
  output logic [GEN_W-1:0]     gen_count
`ifdef LIFE_STABLE_DETECT_EN
  ,
  output logic                 stable
`endif
);

  localparam int              c_FC_W    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FRAMES_PER_GEN - 1);

  localparam logic [2:0] c_ST_SCAN = 3'd0;
  localparam logic [2:0] c_ST_P0   = 3'd1;
  localparam logic [2:0] c_ST_P1   = 3'd2;
  localparam logic [2:0] c_ST_P2   = 3'd3;
  localparam logic [2:0] c_ST_A    = 3'd4;
  localparam logic [2:0] c_ST_B    = 3'd5;
  localparam logic [2:0] c_ST_C    = 3'd6;
  localparam logic [2:0] c_ST_DONE = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [2:0]        r_row;
  logic [2:0]        r_scan_addr;
  logic [c_FC_W-1:0] r_frame_cnt;
  logic              r_pending;
  logic [7:0]        r_prev;
  logic [7:0]        r_cur;
  logic [7:0]        r_nxt;
  logic [7:0]        r_saved0;
  logic              r_disp_valid;
  logic [2:0]        r_disp_addr;
  logic [GEN_W-1:0]  r_gen_count;

  logic w_scan;
  logic w_scan_rd;
  logic w_frame_done;
  logic w_auto_ok;
  logic w_auto_set;
  logic w_start;

`ifdef LIFE_STABLE_DETECT_EN
  logic r_changed;
  logic r_stable;
  assign w_auto_ok = ~r_stable;
  assign stable    = r_stable;
`else
  assign w_auto_ok = 1'b1;
`endif

  assign w_scan       = (r_state == c_ST_SCAN);
  assign w_scan_rd    = w_scan & ~bus.load_valid;
  // A frame ends only when the row-7 read is actually issued (not displaced by a load).
  assign w_frame_done = w_scan_rd & (r_scan_addr == 3'd7);
  assign w_auto_set   = w_frame_done & run & w_auto_ok & (r_frame_cnt == c_FC_LAST);
  assign w_start      = w_frame_done & (r_pending | step | w_auto_set);

  // ---------------------------------------------------------------- state
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_SCAN: if (w_start) w_state_nxt = c_ST_P0;
      c_ST_P0:   w_state_nxt = c_ST_P1;
      c_ST_P1:   w_state_nxt = c_ST_P2;
      c_ST_P2:   w_state_nxt = c_ST_A;
      c_ST_A:    w_state_nxt = c_ST_B;
      c_ST_B:    w_state_nxt = c_ST_C;
      c_ST_C:    w_state_nxt = (r_row == 3'd7) ? c_ST_DONE : c_ST_A;
      default:   w_state_nxt = c_ST_SCAN;
    endcase
  end

  always_comb begin
    busy           = 1'b1;
    bus.load_ready = 1'b0;
    bus.mem_addr   = 3'd0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 8'h00;
    case (r_state)
      c_ST_SCAN: begin
        busy = 1'b0;
        if (bus.load_valid) begin
          bus.load_ready = 1'b1;
          bus.mem_addr   = bus.load_row;
          bus.mem_we     = 1'b1;
          bus.mem_wdata  = bus.load_data;
        end else begin
          bus.mem_addr = r_scan_addr;
        end
      end
      c_ST_P0: bus.mem_addr = 3'd7;
      c_ST_P1: bus.mem_addr = 3'd0;
      c_ST_A:  bus.mem_addr = r_row + 3'd1;
      c_ST_C: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_row;
        bus.mem_wdata = bus.dec_out;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_row        <= 3'd0;
      r_scan_addr  <= 3'd0;
      r_frame_cnt  <= '0;
      r_pending    <= 1'b0;
      r_prev       <= 8'h00;
      r_cur        <= 8'h00;
      r_nxt        <= 8'h00;
      r_saved0     <= 8'h00;
      r_disp_valid <= 1'b0;
      r_disp_addr  <= 3'd0;
      r_gen_count  <= '0;
    end else begin
      r_disp_valid <= w_scan_rd;
      if (w_scan_rd) begin
        r_disp_addr <= r_scan_addr;
        r_scan_addr <= r_scan_addr + 3'd1;
      end

      if (w_frame_done && run) begin
        r_frame_cnt <= (r_frame_cnt == c_FC_LAST) ? '0 : r_frame_cnt + 1'b1;
      end

      // The request that launches an update is consumed on launch; anything
      // arriving while busy stays pending for the next frame boundary.
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (step || w_auto_set) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        c_ST_P1: r_prev <= bus.mem_rdata;
        c_ST_P2: begin
          r_cur    <= bus.mem_rdata;
          r_saved0 <= bus.mem_rdata;
          r_row    <= 3'd0;
        end
        c_ST_B:  r_nxt <= (r_row == 3'd7) ? r_saved0 : bus.mem_rdata;
        c_ST_C: begin
          r_prev <= r_cur;
          r_cur  <= r_nxt;
          r_row  <= r_row + 3'd1;
        end
        c_ST_DONE: begin
          r_gen_count <= r_gen_count + 1'b1;
          r_frame_cnt <= '0;
          r_scan_addr <= 3'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef LIFE_STABLE_DETECT_EN
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_changed <= 1'b0;
      r_stable  <= 1'b0;
    end else begin
      if (r_state == c_ST_P0) begin
        r_changed <= 1'b0;
      end else if (r_state == c_ST_C && bus.dec_out != r_cur) begin
        r_changed <= 1'b1;
      end
      if (w_scan && bus.load_valid) begin
        r_stable <= 1'b0;
      end else if (r_state == c_ST_DONE) begin
        r_stable <= ~r_changed;
      end
    end
  end
`endif

  assign bus.dec_in     = r_cur;
  assign bus.dec_a      = r_prev;
  assign bus.dec_b      = r_nxt;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_addr  = r_disp_addr;
  // Memory data arrives one cycle after the scan read, so the row is forwarded directly.
  assign bus.disp_row   = r_disp_valid ? bus.mem_rdata : 8'h00;
  assign gen_count      = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_gen_sequencer
// Purpose  : Self-checking bench for life_gen_sequencer against a whole-grid
//            Game of Life reference model with toroidal wrap.
// Revision : 1.0
// ============================================================================
module tb_life_gen_sequencer;

  logic        ph1     = 1'b0;
  logic        reset_n = 1'b0;
  logic        run     = 1'b0;
  logic        step    = 1'b0;
  logic        busy;
  logic [15:0] gen_count;
`ifdef LIFE_STABLE_DETECT_EN
  logic        stable;
`endif

  life_gen_sequencer_if bus();

  life_gen_sequencer #(.FRAMES_PER_GEN(2), .GEN_W(16)) u_dut (
    .ph1(ph1), .reset_n(reset_n), .run(run), .step(step), .bus(bus),
    .busy(busy), .gen_count(gen_count)
`ifdef LIFE_STABLE_DETECT_EN
    , .stable(stable)
`endif
  );

  always #5 ph1 = ~ph1;

  // Single-port row memory, one-cycle read latency
  logic [7:0] mem [8] = '{default: 8'h00};
  logic [7:0] rdata_q = 8'h00;
  always @(posedge ph1) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else            rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  function automatic logic [7:0] dec_model(input logic [7:0] a, input logic [7:0] m, input logic [7:0] b);
    logic [7:0] o;
    int n;
    o = 8'h00;
    for (int c = 0; c < 8; c++) begin
      n = 0;
      for (int d = -1; d <= 1; d++) begin
        n += int'(a[3'((c + d + 8) % 8)]) + int'(b[3'((c + d + 8) % 8)]);
        if (d != 0) n += int'(m[3'((c + d + 8) % 8)]);
      end
      o[3'(c)] = (n == 3) || (n == 2 && m[3'(c)]);
    end
    return o;
  endfunction
  assign bus.dec_out = dec_model(bus.dec_a, bus.dec_in, bus.dec_b);

  int          cyc = 0;
  logic [2:0]  last_addr = 3'd0;
  logic        last_we = 1'b0;
  always @(posedge ph1) begin
    cyc       <= cyc + 1;
    last_addr <= bus.mem_addr;
    last_we   <= bus.mem_we;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_gen  = 0;
  logic [7:0] ref_grid [8] = '{default: 8'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // Whole-grid next generation, rows and columns both toroidal
  task automatic ref_step();
    logic [7:0] ng [8];
    int n;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(ref_grid[3'((r + dr + 8) % 8)][3'((c + dc + 8) % 8)]);
        ng[3'(r)][3'(c)] = (n == 3) || (n == 2 && ref_grid[3'(r)][3'(c)]);
      end
    end
    ref_grid = ng;
  endtask

  task automatic do_load(input int r, input logic [7:0] d);
    int w;
    bus.load_valid = 1'b1;
    bus.load_row   = 3'(r);
    bus.load_data  = d;
    #1;
    w = 0;
    while (!bus.load_ready && w < 60) begin
      tick();
      w++;
    end
    chk("load_ready", {31'd0, bus.load_ready}, 1);
    tick();
    bus.load_valid = 1'b0;
    chk("disp_after_load", {31'd0, bus.disp_valid}, 0);
    ref_grid[3'(r)] = d;
  endtask

  task automatic load_grid(input logic [63:0] g);
    for (int r = 0; r < 8; r++) do_load(r, g[8*r +: 8]);
  endtask

  task automatic scan_check(input int n, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) nbusy++;
      else if (bus.disp_valid) chk("disp_row", {24'd0, bus.disp_row}, {24'd0, ref_grid[bus.disp_addr]});
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_gen"},   {16'd0, gen_count}, 0);
    chk({tag, "_we"},    {31'd0, bus.mem_we}, 0);
    chk({tag, "_addr"},  {29'd0, bus.mem_addr}, 0);
    chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 0);
    chk({tag, "_rdy"},   {31'd0, bus.load_ready}, 0);
    chk({tag, "_dv"},    {31'd0, bus.disp_valid}, 0);
    chk({tag, "_drow"},  {24'd0, bus.disp_row}, 0);
    chk({tag, "_daddr"}, {29'd0, bus.disp_addr}, 0);
    chk({tag, "_dec"},   {8'd0, bus.dec_in, bus.dec_a, bus.dec_b}, 0);
`ifdef LIFE_STABLE_DETECT_EN
    chk({tag, "_stable"}, {31'd0, stable}, 0);
`endif
  endtask

  // Waits for an update, checks its timing and the resulting grid.
  task automatic check_update(input string tag, input int step_at, input int run_off_at, output int t_start);
    int w, k, nw, bad;
    w = 0;
    t_start = 0;
    while (!busy && w < 100) begin
      tick();
      w++;
    end
    chk({tag, "_start"}, {31'd0, busy}, 1);
    if (busy) begin
      t_start = cyc;
      chk({tag, "_pre_addr"}, {29'd0, last_addr}, 7);
      chk({tag, "_pre_we"}, {31'd0, last_we}, 0);
      chk({tag, "_p0_disp"}, {28'd0, bus.disp_valid, bus.disp_addr}, {28'd0, 1'b1, 3'd7});
      k = 1; nw = 0; bad = 0;
      while (busy && k < 40) begin
        if (k > 1 && bus.disp_valid) bad++;
        if (bus.mem_we) begin
          chk({tag, "_we_cyc"}, k, 6 + 3 * nw);
          chk({tag, "_we_addr"}, {29'd0, bus.mem_addr}, nw);
          nw++;
        end
        step = (k == step_at);
        if (k == run_off_at) run = 1'b0;
        tick();
        k++;
      end
      step = 1'b0;
      chk({tag, "_busy_len"}, k - 1, 28);
      chk({tag, "_n_we"}, nw, 8);
      chk({tag, "_disp_quiet"}, bad, 0);
      ref_step();
      exp_gen++;
      chk({tag, "_gen"}, {16'd0, gen_count}, exp_gen);
      for (int r = 0; r < 8; r++) chk({tag, "_row"}, {24'd0, mem[r]}, {24'd0, ref_grid[r]});
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  int t0, t1, t2, nb, w;

  initial begin
    bus.load_valid = 1'b0;
    bus.load_row   = 3'd0;
    bus.load_data  = 8'h00;
    #2;
    chk_idle("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Vertical blinker
    load_grid(64'h0000_0008_0808_0000);
    scan_check(20, nb);
    pulse_step();
    check_update("blink1", 0, 0, t0);
    chk("blink_r3", {24'd0, mem[3]}, 32'h1C);
    chk("blink_r2", {24'd0, mem[2]}, 32'h00);
    pulse_step();
    check_update("blink2", 0, 0, t0);
    chk("blink_back_r2", {24'd0, mem[2]}, 32'h08);
    scan_check(16, nb);

    // Toroidal wrap across row 7 / row 0 and column 7 / column 0
    load_grid(64'h0100_0000_0000_0101);
    pulse_step();
    check_update("torus", 0, 0, t0);
    chk("torus_r0", {24'd0, mem[0]}, 32'h83);

    // Step during an update queues exactly one more generation
    pulse_step();
    check_update("mid_step", 12, 0, t0);
    check_update("mid_follow", 0, 0, t0);

    // Back-to-back step pulses collapse into one generation
    w = 0;
    while ((busy || bus.mem_addr != 3'd1) && w < 100) begin tick(); w++; end
    pulse_step(); tick(); pulse_step();
    check_update("collapse", 0, 0, t0);
    scan_check(40, nb);
    chk("collapse_idle", nb, 0);

    // Host load held across an update is accepted only once back in scan
    pulse_step();
    w = 0;
    while (!busy && w < 100) begin tick(); w++; end
    bus.load_valid = 1'b1; bus.load_row = 3'd5; bus.load_data = 8'hA5;
    #1;
    chk("held_rdy_busy", {31'd0, bus.load_ready}, 0);
    nb = 0; w = 0;
    while (!bus.load_ready && w < 60) begin
      if (!busy) nb++;
      tick();
      w++;
    end
    chk("held_rdy", {31'd0, bus.load_ready}, 1);
    chk("held_idle", {31'd0, busy}, 0);
    chk("held_gap", nb, 0);
    tick();
    bus.load_valid = 1'b0;
    ref_step();
    exp_gen++;
    ref_grid[5] = 8'hA5;
    chk("held_gen", {16'd0, gen_count}, exp_gen);
    for (int r = 0; r < 8; r++) chk("held_row", {24'd0, mem[r]}, {24'd0, ref_grid[r]});

    // Automatic generations every two frames; run dropped mid-update
    load_grid(64'h0000_0008_0808_0000);
    run = 1'b1;
    check_update("auto1", 0, 0, t0);
    check_update("auto2", 0, 0, t1);
    check_update("auto3", 0, 15, t2);
    chk("auto_period1", t1 - t0, 44);
    chk("auto_period2", t2 - t1, 44);
    scan_check(60, nb);
    chk("auto_stopped", nb, 0);

    // Random grids
    for (int it = 0; it < 4; it++) begin
      load_grid({$urandom(), $urandom()});
      scan_check(16, nb);
      pulse_step();
      check_update("rand", 0, 0, t0);
    end

    // Reset at cycle 10 of an update
    pulse_step();
    w = 0;
    while (!busy && w < 100) begin tick(); w++; end
    repeat (9) tick();
    chk("rst_mid_inupd", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    tick(); tick();
    reset_n = 1'b1;
    exp_gen = 0;
    tick();

`ifdef LIFE_STABLE_DETECT_EN
    // Still life: auto generations stop once stable, step still runs
    load_grid(64'h0000_0018_1800_0000);
    run = 1'b1;
    check_update("stab_auto", 0, 0, t0);
    chk("stable_set", {31'd0, stable}, 1);
    scan_check(120, nb);
    chk("stab_no_auto", nb, 0);
    pulse_step();
    check_update("stab_step", 0, 0, t0);
    chk("stab_r3", {24'd0, mem[3]}, 32'h18);
    run = 1'b0;
    do_load(0, 8'h00);
    chk("stable_cleared", {31'd0, stable}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
